// File: rtl/delay_timer_if.sv
// Terminal-count bundle carried from the delay timer to its consumer.
`timescale 1ns/1ps
interface delay_timer_if;
    logic tc;

    modport master (output tc);
    modport slave  (input  tc);
endinterface

// File: rtl/delay_timer.sv
// Programmable clock-cycle delay / tick generator for the microwave timer path.
// Periodic mode emits a one-cycle tc pulse every DELAY edges; one-shot mode latches tc.
`timescale 1ns/1ps
module delay_timer #(
    parameter int unsigned DELAY    = 5,
    parameter int unsigned WIDTH    = 8,
    parameter bit          PERIODIC = 1'b1
) (
    input  logic          clk,
    input  logic          clr,
    delay_timer_if.master tmr
);

    generate
        if (DELAY < 1 || 64'(DELAY) > (64'd1 << WIDTH)) begin : g_bad_delay
            $error("delay_timer: DELAY must lie in 1 .. 2**WIDTH");
        end
    endgenerate

    // Terminal value; DELAY = 2**WIDTH maps exactly onto the all-ones count.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(DELAY - 1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             tc_reg;
    logic             tc_next;
    logic             hold;

    // In one-shot mode a set tc freezes all state until the next reset.
    assign hold = (PERIODIC == 1'b0) && tc_reg;

    always_comb begin
        count_next = count_reg;
        tc_next    = tc_reg;
        if (!hold) begin
            if (count_reg == LAST) begin
                count_next = '0;
                tc_next    = 1'b1;
            end else begin
                count_next = count_reg + WIDTH'(1);
                tc_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    assign tmr.tc = tc_reg;

endmodule

// File: tb/tb_delay_timer.sv
// Directed self-checking bench for delay_timer across periodic, one-shot,
// DELAY=1 and full-width DELAY configurations.
`timescale 1ns/1ps
module tb_delay_timer;

    logic clk = 1'b0;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;
    logic clr_c = 1'b0;
    logic clr_d = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_timer_if if_a ();
    delay_timer_if if_b ();
    delay_timer_if if_c ();
    delay_timer_if if_d ();

    delay_timer #(.DELAY(5),   .WIDTH(8), .PERIODIC(1'b1)) dut_a (.clk(clk), .clr(clr_a), .tmr(if_a));
    delay_timer #(.DELAY(5),   .WIDTH(8), .PERIODIC(1'b0)) dut_b (.clk(clk), .clr(clr_b), .tmr(if_b));
    delay_timer #(.DELAY(1),   .WIDTH(8), .PERIODIC(1'b1)) dut_c (.clk(clk), .clr(clr_c), .tmr(if_c));
    delay_timer #(.DELAY(256), .WIDTH(8), .PERIODIC(1'b1)) dut_d (.clk(clk), .clr(clr_d), .tmr(if_d));

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: periodic DELAY=5, two reset edges then twelve counting edges
        for (int e = 1; e <= 2; e++) begin
            tick();
            check($sformatf("t1_rst_e%0d", e), if_a.tc, 1'b0);
        end
        clr_a = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("t1_run_e%0d", e), if_a.tc, (e == 5 || e == 10));
        end

        // 2: reset mid-count discards the partial delay
        clr_a = 1'b0;
        tick();
        clr_a = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("t2_pre_e%0d", e), if_a.tc, 1'b0);
        end
        clr_a = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            check($sformatf("t2_rst_e%0d", e), if_a.tc, 1'b0);
        end
        clr_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("t2_post_e%0d", e), if_a.tc, (e == 5));
        end

        // 3: async reset while tc is high (count sits at 1 after edge 6 above)
        for (int e = 7; e <= 10; e++) begin
            tick();
            check($sformatf("t3_run_e%0d", e), if_a.tc, (e == 10));
        end
        #2;
        clr_a = 1'b0;
        #1;
        check("t3_async_drop", if_a.tc, 1'b0);
        tick();
        check("t3_held", if_a.tc, 1'b0);
        clr_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("t3_post_e%0d", e), if_a.tc, (e == 5));
        end

        // 4: one-shot DELAY=5 latches, then reset and re-arm
        clr_b = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("t4_run_e%0d", e), if_b.tc, (e >= 5));
        end
        #2;
        clr_b = 1'b0;
        #1;
        check("t4_async_drop", if_b.tc, 1'b0);
        tick();
        clr_b = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t4_rearm_e%0d", e), if_b.tc, (e >= 5));
        end

        // 5: DELAY=1 stays high from edge 1 on
        check("t5_before", if_c.tc, 1'b0);
        clr_c = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("t5_e%0d", e), if_c.tc, 1'b1);
        end

        // 6: DELAY=256 with an 8-bit counter, no premature wrap pulse
        clr_d = 1'b1;
        for (int e = 1; e <= 520; e++) begin
            tick();
            check($sformatf("t6_e%0d", e), if_d.tc, (e == 256 || e == 512));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_timer.md
Name: delay_timer

Overview:
- Programmable clock-cycle delay/tick generator for the microwave controller timer path.
- Counts rising edges of clk after reset release.
- Asserts terminal-count output tc once DELAY cycles have elapsed.
- Either repeats periodically (timebase tick) or latches once (one-shot delay), selected by parameter.

Parameters:
- DELAY, 5, number of clk cycles per terminal count; legal range 1 to 2^WIDTH. Values outside this range are an elaboration error.
- WIDTH, 8, bit width of the internal cycle counter.
- PERIODIC, 1, selects the mode:
  - 1: tc is a one-cycle pulse every DELAY cycles, with auto-reload.
  - 0: one-shot; tc latches high and stays high until reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset. clr=0 clears all state immediately; clr=1 allows normal operation.
- tc  output  1  terminal count, registered output.

Behaviour:
- Reset (clr=0, asynchronous): internal count <= 0 and tc <= 0 immediately, independent of clk. Both are held while clr=0.
- Reset release: no internal synchronizer. Deassertion of clr must meet recovery/removal timing to clk. The first rising edge with clr=1 is counted as edge 1.
- Counter, per rising edge with clr=1:
  - If count == DELAY-1: count <= 0 and tc <= 1.
  - Otherwise: count <= count+1 and tc <= 0.
- Latency (PERIODIC=1): tc is high for exactly one cycle, starting after edge DELAY, then again after edges 2*DELAY, 3*DELAY, and so on. The period is DELAY cycles with a duty cycle of 1/DELAY.
- PERIODIC=0:
  - Once tc is set, it stays 1 and count freezes at 0.
  - Further edges change nothing until clr=0.
- DELAY=1:
  - PERIODIC=1: tc goes high after edge 1 and stays high continuously.
  - PERIODIC=0: same waveform, with tc latched.
- Reset mid-count: count returns to 0 immediately. A fresh full DELAY cycles is required after release before tc asserts. A partially elapsed delay is never resumed.
- Reset while tc=1: tc drops to 0 asynchronously, in the same instant clr falls.
- Wrap-around: count never exceeds DELAY-1, so there is no overflow for legal parameters.
- No X propagation: all registers are defined by reset. tc is never combinationally derived from clr or count.

Test Plan:
1. DELAY=5, PERIODIC=1; clr=0 for 2 edges, then clr=1 for 12 edges -> tc=0 throughout reset. tc=1 only in the cycles after edge 5 and edge 10; 0 elsewhere.
2. DELAY=5, PERIODIC=1; release reset, run 3 edges, drive clr=0 between edges for 2 cycles, release, run 6 edges -> tc stays 0 through the first 3 edges and the reset. tc=1 only after edge 5 counted from the second release.
3. DELAY=5, PERIODIC=1; assert clr=0 while tc=1, mid-cycle (no clk edge) -> tc falls to 0 immediately. Next tc pulse occurs 5 edges after release.
4. DELAY=5, PERIODIC=0; run 12 edges -> tc rises after edge 5 and remains 1 through edge 12. Pulsing clr=0 returns tc to 0, and tc re-asserts 5 edges after release.
5. DELAY=1, PERIODIC=1; release reset, run 4 edges -> tc=0 before edge 1, tc=1 continuously after edge 1.
6. DELAY=256, WIDTH=8, PERIODIC=1; run 520 edges -> tc pulses only after edges 256 and 512. No premature pulse from counter wrap.
